axi_moving_avg_pow2: RTL and testbench



---
 rtl/axi_moving_avg_pow2.sv | 140 ++++++++++++++
 tb/tb_axi_moving_avg_pow2.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_moving_avg_pow2.sv
// Streaming moving average over 2^k samples with round-half-up, clip, length-change flush
// and an optional warm-up hold-off. One output register stage gives 1-cycle latency.
module axi_moving_avg_pow2 #(
  parameter int WIDTH        = 16,
  parameter int MAX_LEN_LOG2 = 8,
  parameter bit HOLDOFF      = 1'b0
) (
  input  logic                              clk,
  input  logic                              aresetn,
  input  logic                              clear,
  input  logic [$clog2(MAX_LEN_LOG2+1)-1:0] len_log2,
  input  logic [WIDTH-1:0]                  i_tdata,
  input  logic                              i_tlast,
  input  logic                              i_tvalid,
  output logic                              i_tready,
  output logic [WIDTH-1:0]                  o_tdata,
  output logic                              o_tuser,
  output logic                              o_tlast,
  output logic                              o_tvalid,
  input  logic                              o_tready
);
  localparam int KW    = $clog2(MAX_LEN_LOG2+1);
  localparam int AW    = MAX_LEN_LOG2;
  localparam int DEPTH = 1 << MAX_LEN_LOG2;
  localparam int SW    = WIDTH + MAX_LEN_LOG2 + 1;
  localparam int FW    = MAX_LEN_LOG2 + 1;

  localparam logic signed [SW-1:0] AVG_MAX = {{(SW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [SW-1:0] AVG_MIN = {{(SW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             user;
    logic             last;
  } beat_t;

  logic [KW-1:0]        k_cur, k_q, k_d;
  logic                 kchg_q, kchg_d;
  logic signed [SW-1:0] sum_q, sum_d;
  logic [FW-1:0]        fill_q, fill_d;
  logic [AW-1:0]        wp_q, wp_d;
  beat_t                out_q, out_d;
  logic                 o_tvalid_q, o_tvalid_d;
  logic [WIDTH-1:0]     hist_q [DEPTH];

  logic                 flush, acc, emit, full_new;
  logic [FW-1:0]        len_w, fill_inc, fill_new, base_fill;
  logic [AW-1:0]        rd_addr, base_wp;
  logic signed [SW-1:0] base_sum, x_ext, old_ext, sum_new, rnd, rnd_sum, shifted;
  logic [WIDTH-1:0]     oldest, avg;

  assign k_cur = (len_log2 > KW'(MAX_LEN_LOG2)) ? KW'(MAX_LEN_LOG2) : len_log2;

  // k is sampled every cycle; a change is seen as a flush one cycle later, so the
  // sample accepted in the change cycle still runs under the old k.
  assign flush = clear | kchg_q;
  assign len_w = FW'(1) << k_q;

  assign i_tready = o_tready | ~o_tvalid_q;
  assign acc      = i_tvalid & i_tready;

  // Read before the write at the same edge: when L == depth rd_addr equals wp.
  assign rd_addr = wp_q - len_w[AW-1:0];
  assign oldest  = (!flush && fill_q == len_w) ? hist_q[rd_addr] : '0;

  assign base_sum  = flush ? '0 : sum_q;
  assign base_fill = flush ? '0 : fill_q;
  assign base_wp   = flush ? '0 : wp_q;

  assign x_ext    = {{(SW-WIDTH){i_tdata[WIDTH-1]}}, i_tdata};
  assign old_ext  = {{(SW-WIDTH){oldest[WIDTH-1]}}, oldest};
  assign sum_new  = base_sum + x_ext - old_ext;
  assign fill_inc = base_fill + FW'(1);
  assign fill_new = (fill_inc >= len_w) ? len_w : fill_inc;
  assign full_new = (fill_new == len_w);

  assign rnd     = (k_q == '0) ? '0 : (SW'(1) << (k_q - KW'(1)));
  assign rnd_sum = sum_new + rnd;
  assign shifted = rnd_sum >>> k_q;
  assign avg     = (shifted > AVG_MAX) ? AVG_MAX[WIDTH-1:0] :
                   (shifted < AVG_MIN) ? AVG_MIN[WIDTH-1:0] : shifted[WIDTH-1:0];

  assign emit = acc & (!HOLDOFF || full_new);

  always_comb begin
    k_d        = k_cur;
    kchg_d     = (k_cur != k_q);
    sum_d      = sum_q;
    fill_d     = fill_q;
    wp_d       = wp_q;
    out_d      = out_q;
    o_tvalid_d = o_tvalid_q;
    if (flush) begin
      sum_d  = '0;
      fill_d = '0;
      wp_d   = '0;
    end
    if (acc) begin
      sum_d  = sum_new;
      fill_d = fill_new;
      wp_d   = base_wp + AW'(1);
    end
    if (emit) begin
      o_tvalid_d = 1'b1;
      out_d      = '{data: avg, user: full_new, last: i_tlast};
    end else if (o_tready) begin
      o_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      k_q        <= '0;
      kchg_q     <= 1'b0;
      sum_q      <= '0;
      fill_q     <= '0;
      wp_q       <= '0;
      out_q      <= '0;
      o_tvalid_q <= 1'b0;
    end else begin
      k_q        <= k_d;
      kchg_q     <= kchg_d;
      sum_q      <= sum_d;
      fill_q     <= fill_d;
      wp_q       <= wp_d;
      out_q      <= out_d;
      o_tvalid_q <= o_tvalid_d;
    end
  end

  // History needs no reset: fill gates every read.
  always_ff @(posedge clk) begin
    if (acc) hist_q[base_wp] <= i_tdata;
  end

  assign o_tdata  = out_q.data;
  assign o_tuser  = out_q.user;
  assign o_tlast  = out_q.last;
  assign o_tvalid = o_tvalid_q;
endmodule

// File: tb/tb_axi_moving_avg_pow2.sv
// Directed bench for axi_moving_avg_pow2: one DUT emitting every sample, one with hold-off.
module tb_axi_moving_avg_pow2;
  logic clk = 1'b0;
  logic aresetn = 1'b0;
  logic clear = 1'b0;
  logic [3:0] len_log2 = 4'd0;
  logic signed [15:0] i_tdata = '0;
  logic i_tlast = 1'b0, i_tvalid = 1'b0;
  logic o_tready = 1'b1, o_tready1 = 1'b1;
  logic i_tready0, i_tready1;
  logic signed [15:0] o_tdata0, o_tdata1;
  logic o_tuser0, o_tuser1, o_tlast0, o_tlast1, o_tvalid0, o_tvalid1;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  axi_moving_avg_pow2 #(.WIDTH(16), .MAX_LEN_LOG2(8), .HOLDOFF(1'b0)) dut0 (
    .clk(clk), .aresetn(aresetn), .clear(clear), .len_log2(len_log2),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready0),
    .o_tdata(o_tdata0), .o_tuser(o_tuser0), .o_tlast(o_tlast0), .o_tvalid(o_tvalid0),
    .o_tready(o_tready));

  axi_moving_avg_pow2 #(.WIDTH(16), .MAX_LEN_LOG2(8), .HOLDOFF(1'b1)) dut1 (
    .clk(clk), .aresetn(aresetn), .clear(clear), .len_log2(len_log2),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready1),
    .o_tdata(o_tdata1), .o_tuser(o_tuser1), .o_tlast(o_tlast1), .o_tvalid(o_tvalid1),
    .o_tready(o_tready1));

  // All tasks begin and end just after a falling edge.
  task automatic setup(input int k);
    len_log2 = 4'(k);
    i_tvalid = 1'b0;
    clear = 1'b1;
    repeat (3) @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic step(input logic signed [15:0] x, input logic last);
    i_tvalid = 1'b1;
    i_tdata  = x;
    i_tlast  = last;
    @(negedge clk);
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
  endtask

  task automatic test_reset;
    aresetn = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if (o_tvalid0 !== 1'b0 || o_tdata0 !== 16'sd0 || o_tuser0 !== 1'b0 || o_tlast0 !== 1'b0) begin
      fails++;
      $display("FAIL reset_outputs got v=%b d=%0d u=%b l=%b want 0 0 0 0", o_tvalid0, o_tdata0, o_tuser0, o_tlast0);
    end
    tests++;
    if (i_tready0 !== 1'b1) begin
      fails++;
      $display("FAIL reset_ready got %b want 1", i_tready0);
    end
    aresetn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int xs[5] = '{4, 8, 12, 16, 20};
    int ex[5] = '{1, 3, 6, 10, 14};
    setup(2);
    for (int i = 0; i < 5; i++) begin
      step(16'(xs[i]), (i == 2 || i == 4));
      tests++;
      if (o_tvalid0 !== 1'b1 || o_tdata0 !== 16'(ex[i]) || o_tuser0 !== (i >= 3) ||
          o_tlast0 !== (i == 2 || i == 4)) begin
        fails++;
        $display("FAIL basic[%0d] got v=%b d=%0d u=%b l=%b want 1 %0d %b %b", i, o_tvalid0,
                 o_tdata0, o_tuser0, o_tlast0, ex[i], (i >= 3), (i == 2 || i == 4));
      end
    end
  endtask

  task automatic test_holdoff;
    int xs[5] = '{4, 8, 12, 16, 20};
    int ex[5] = '{0, 0, 0, 10, 14};
    setup(2);
    for (int i = 0; i < 5; i++) begin
      step(16'(xs[i]), (i == 2 || i == 4));
      tests++;
      if (i < 3) begin
        if (o_tvalid1 !== 1'b0) begin
          fails++;
          $display("FAIL holdoff_suppress[%0d] got valid %b want 0", i, o_tvalid1);
        end
      end else if (o_tvalid1 !== 1'b1 || o_tdata1 !== 16'(ex[i]) || o_tuser1 !== 1'b1 ||
                   o_tlast1 !== (i == 4)) begin
        fails++;
        $display("FAIL holdoff[%0d] got v=%b d=%0d u=%b l=%b want 1 %0d 1 %b", i, o_tvalid1,
                 o_tdata1, o_tuser1, o_tlast1, ex[i], (i == 4));
      end
    end
  endtask

  task automatic test_boundary;
    int vals[4] = '{5, -7, 32767, -32768};
    setup(3);
    for (int i = 0; i < 8; i++) begin
      step(16'sd32767, 1'b0);
      if (i == 0) begin
        tests++;
        if (o_tdata0 !== 16'sd4096) begin
          fails++;
          $display("FAIL pos_first got %0d want 4096", o_tdata0);
        end
      end
    end
    tests++;
    if (o_tdata0 !== 16'sd32767 || o_tuser0 !== 1'b1) begin
      fails++;
      $display("FAIL pos_full got d=%0d u=%b want 32767 1", o_tdata0, o_tuser0);
    end
    setup(3);
    for (int i = 0; i < 8; i++) begin
      step(-16'sd32768, 1'b0);
      if (i == 0) begin
        tests++;
        if (o_tdata0 !== -16'sd4096) begin
          fails++;
          $display("FAIL neg_first got %0d want -4096", o_tdata0);
        end
      end
    end
    tests++;
    if (o_tdata0 !== -16'sd32768 || o_tuser0 !== 1'b1) begin
      fails++;
      $display("FAIL neg_full got d=%0d u=%b want -32768 1", o_tdata0, o_tuser0);
    end
    setup(0);
    for (int i = 0; i < 4; i++) begin
      step(16'(vals[i]), 1'b0);
      tests++;
      if (o_tdata0 !== 16'(vals[i]) || o_tuser0 !== 1'b1) begin
        fails++;
        $display("FAIL k0[%0d] got d=%0d u=%b want %0d 1", i, o_tdata0, o_tuser0, vals[i]);
      end
    end
  endtask

  task automatic test_wrap;
    int xs[300];
    int s, e;
    setup(8);
    for (int i = 0; i < 300; i++) xs[i] = i * 200 - 29900;
    for (int i = 0; i < 300; i++) begin
      step(16'(xs[i]), 1'b0);
      s = 0;
      for (int j = (i > 255 ? i - 255 : 0); j <= i; j++) s += xs[j];
      e = (s + 128) >>> 8;
      tests++;
      if (o_tdata0 !== 16'(e) || o_tuser0 !== (i >= 255)) begin
        fails++;
        $display("FAIL wrap[%0d] got d=%0d u=%b want %0d %b", i, o_tdata0, o_tuser0, e, (i >= 255));
      end
    end
  endtask

  task automatic test_len_change;
    int ex[3] = '{88, 25, 50};
    logic eu[3] = '{1'b1, 1'b0, 1'b1};
    setup(2);
    for (int i = 0; i < 6; i++) step(16'sd100, 1'b0);
    tests++;
    if (o_tdata0 !== 16'sd100 || o_tuser0 !== 1'b1) begin
      fails++;
      $display("FAIL steady got d=%0d u=%b want 100 1", o_tdata0, o_tuser0);
    end
    len_log2 = 4'd1;
    for (int i = 0; i < 3; i++) begin
      step(16'sd50, 1'b0);
      tests++;
      if (o_tdata0 !== 16'(ex[i]) || o_tuser0 !== eu[i]) begin
        fails++;
        $display("FAIL len_change[%0d] got d=%0d u=%b want %0d %b", i, o_tdata0, o_tuser0, ex[i], eu[i]);
      end
    end
  endtask

  task automatic test_clear;
    setup(1);
    step(16'sd1000, 1'b0);
    step(16'sd1000, 1'b0);
    clear = 1'b1;
    step(16'sd40, 1'b0);
    clear = 1'b0;
    tests++;
    if (o_tdata0 !== 16'sd20 || o_tuser0 !== 1'b0) begin
      fails++;
      $display("FAIL clear_first got d=%0d u=%b want 20 0", o_tdata0, o_tuser0);
    end
    step(16'sd40, 1'b0);
    tests++;
    if (o_tdata0 !== 16'sd40 || o_tuser0 !== 1'b1) begin
      fails++;
      $display("FAIL clear_second got d=%0d u=%b want 40 1", o_tdata0, o_tuser0);
    end
  endtask

  task automatic test_backpressure;
    logic signed [15:0] smp[1000];
    logic lst[1000];
    int exd[1000];
    logic exu[1000];
    int in_idx, out_idx, cyc, s, e;
    logic acc, stall_prev;
    logic signed [15:0] hd;
    logic hu, hl;
    for (int i = 0; i < 1000; i++) begin
      smp[i] = 16'($urandom_range(0, 65535));
      lst[i] = ($urandom_range(0, 7) == 0);
    end
    for (int i = 0; i < 1000; i++) begin
      s = 0;
      for (int j = (i > 3 ? i - 3 : 0); j <= i; j++) s += int'(smp[j]);
      e = (s + 2) >>> 2;
      if (e > 32767) e = 32767;
      if (e < -32768) e = -32768;
      exd[i] = e;
      exu[i] = (i >= 3);
    end
    setup(2);
    in_idx = 0; out_idx = 0; cyc = 0; stall_prev = 1'b0;
    hd = '0; hu = 1'b0; hl = 1'b0;
    while (out_idx < 1000 && cyc < 20000) begin
      o_tready = ($urandom_range(0, 9) < 3);
      if (!i_tvalid && in_idx < 1000 && $urandom_range(0, 4) != 0) begin
        i_tvalid = 1'b1;
        i_tdata  = smp[in_idx];
        i_tlast  = lst[in_idx];
      end
      #1;
      if (stall_prev) begin
        tests++;
        if (o_tvalid0 !== 1'b1 || o_tdata0 !== hd || o_tuser0 !== hu || o_tlast0 !== hl) begin
          fails++;
          $display("FAIL stall_stable got v=%b d=%0d u=%b l=%b want 1 %0d %b %b", o_tvalid0,
                   o_tdata0, o_tuser0, o_tlast0, hd, hu, hl);
        end
      end
      stall_prev = o_tvalid0 && !o_tready;
      if (stall_prev) begin
        hd = o_tdata0; hu = o_tuser0; hl = o_tlast0;
        tests++;
        if (i_tready0 !== 1'b0) begin
          fails++;
          $display("FAIL stall_ready got %b want 0", i_tready0);
        end
      end
      if (o_tvalid0 && o_tready) begin
        tests++;
        if (o_tdata0 !== 16'(exd[out_idx]) || o_tuser0 !== exu[out_idx] || o_tlast0 !== lst[out_idx]) begin
          fails++;
          $display("FAIL bp_out[%0d] got d=%0d u=%b l=%b want %0d %b %b", out_idx, o_tdata0,
                   o_tuser0, o_tlast0, exd[out_idx], exu[out_idx], lst[out_idx]);
        end
        out_idx++;
      end
      acc = i_tvalid && i_tready0;
      @(negedge clk);
      cyc++;
      if (acc) begin
        in_idx++;
        i_tvalid = 1'b0;
        i_tlast  = 1'b0;
      end
    end
    tests++;
    if (out_idx != 1000) begin
      fails++;
      $display("FAIL bp_count got %0d outputs want 1000", out_idx);
    end
    o_tready = 1'b1;
    repeat (2) @(negedge clk);
    tests++;
    if (o_tvalid0 !== 1'b0) begin
      fails++;
      $display("FAIL bp_extra got valid %b want 0", o_tvalid0);
    end
  endtask

  task automatic test_async_reset;
    setup(2);
    o_tready = 1'b0;
    step(16'sd4, 1'b1);
    tests++;
    if (o_tvalid0 !== 1'b1 || i_tready0 !== 1'b0) begin
      fails++;
      $display("FAIL pre_reset got v=%b rdy=%b want 1 0", o_tvalid0, i_tready0);
    end
    #2 aresetn = 1'b0;
    #1;
    tests++;
    if (o_tvalid0 !== 1'b0 || o_tdata0 !== 16'sd0 || o_tlast0 !== 1'b0) begin
      fails++;
      $display("FAIL async_reset got v=%b d=%0d l=%b want 0 0 0", o_tvalid0, o_tdata0, o_tlast0);
    end
    @(negedge clk);
    aresetn = 1'b1;
    o_tready = 1'b1;
    repeat (2) @(negedge clk);
    step(16'sd8, 1'b0);
    tests++;
    if (o_tdata0 !== 16'sd2 || o_tuser0 !== 1'b0) begin
      fails++;
      $display("FAIL post_reset0 got d=%0d u=%b want 2 0", o_tdata0, o_tuser0);
    end
    step(16'sd12, 1'b0);
    tests++;
    if (o_tdata0 !== 16'sd5 || o_tuser0 !== 1'b0) begin
      fails++;
      $display("FAIL post_reset1 got d=%0d u=%b want 5 0", o_tdata0, o_tuser0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_holdoff();
    test_boundary();
    test_wrap();
    test_len_change();
    test_clear();
    test_backpressure();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
